// File: rtl/aes_decipher_ctrl.sv
// ---------------------------------------------------------------------------
// aes_decipher_ctrl
//
// Iterative AES decipher controller. It holds the 128-bit working state and
// steps it through the external aes_decipher_round logic one round per clock:
// one INIT round (AddRoundKey with key Nr), Nr-1 MAIN rounds, then one FINAL
// round with key 0. Supports AES-128 (Nr=10) and AES-256 (Nr=14).
//
// Ports
//   clk          in   1    clock, rising edge
//   reset        in   1    asynchronous, active-high reset
//   next         in   1    start strobe, accepted only while ready=1
//   keylen       in   1    0=AES-128, 1=AES-256, sampled with next
//   block        in   128  ciphertext, sampled with next
//   ready        out  1    idle, able to accept next
//   valid        out  1    result holds a completed plaintext
//   result       out  128  plaintext (state register)
//   round_idx    out  4    round-key index for the key memory
//   round_type   out  2    round type for aes_decipher_round (3 when idle)
//   round_state  out  128  state presented to the round logic
//   round_new    in   128  combinational round-logic output
// ---------------------------------------------------------------------------
module aes_decipher_ctrl #(
    parameter logic [1:0] INIT_ROUND    = 2'd0,
    parameter logic [1:0] MAIN_ROUND    = 2'd1,
    parameter logic [1:0] FINAL_ROUND   = 2'd2,
    parameter int         AES128_ROUNDS = 10,
    parameter int         AES256_ROUNDS = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic         ready,
    output logic         valid,
    output logic [127:0] result,
    output logic [3:0]   round_idx,
    output logic [1:0]   round_type,
    output logic [127:0] round_state,
    input  logic [127:0] round_new
);

    localparam logic [3:0] NR128     = 4'(AES128_ROUNDS);
    localparam logic [3:0] NR256     = 4'(AES256_ROUNDS);
    localparam logic [1:0] IDLE_TYPE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        MAIN,
        FINAL
    } state_t;

    state_t       fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic         keylen_q, keylen_d;
    logic         valid_q, valid_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            round_ctr_q <= '0;
            keylen_q    <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            round_ctr_q <= round_ctr_d;
            keylen_q    <= keylen_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        round_ctr_d = round_ctr_q;
        keylen_d    = keylen_q;
        valid_d     = valid_q;
        round_type  = IDLE_TYPE;

        case (fsm_q)
            IDLE: begin
                if (next) begin
                    state_d     = block;
                    keylen_d    = keylen;
                    round_ctr_d = keylen ? NR256 : NR128;
                    valid_d     = 1'b0;
                    fsm_d       = INIT;
                end
            end
            INIT: begin
                round_type  = INIT_ROUND;
                state_d     = round_new;
                round_ctr_d = (keylen_q ? NR256 : NR128) - 4'd1;
                fsm_d       = MAIN;
            end
            MAIN: begin
                round_type = MAIN_ROUND;
                state_d    = round_new;
                // Counter reaches 0 exactly when entering FINAL, so FINAL
                // always uses round key 0 and the counter never wraps.
                if (round_ctr_q == 4'd1) begin
                    round_ctr_d = 4'd0;
                    fsm_d       = FINAL;
                end else begin
                    round_ctr_d = round_ctr_q - 4'd1;
                end
            end
            FINAL: begin
                round_type = FINAL_ROUND;
                state_d    = round_new;
                valid_d    = 1'b1;
                fsm_d      = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // ready is exactly "in IDLE": it drops on the accepting edge and rises
    // together with valid on the FINAL edge.
    assign ready       = (fsm_q == IDLE);
    assign valid       = valid_q;
    assign result      = state_q;
    assign round_state = state_q;
    assign round_idx   = round_ctr_q;

endmodule
